// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshakes and slice bus for nibble_serial_adder
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_cin;
  logic [SLICE-1:0] slice_s;
  logic             slice_g;
  logic             slice_p;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // master: operand producer, result consumer and the external cla_4 slice
  modport master (
    output in_valid, in_a, in_b, in_c, out_ready, slice_s, slice_g, slice_p,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, slice_a, slice_b, slice_cin
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready, slice_s, slice_g, slice_p,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, slice_a, slice_b, slice_cin
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder feeding an external 4-bit CLA slice one nibble per clock
module nibble_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  nibble_serial_adder_if.slave bus
);
  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [IW-1:0]    index_q;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = '0;
    bus.out_cout  = 1'b0;
    bus.out_ovf   = 1'b0;
    bus.slice_a   = '0;
    bus.slice_b   = '0;
    bus.slice_cin = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.slice_a   = a_q[index_q*SLICE +: SLICE];
        bus.slice_b   = b_q[index_q*SLICE +: SLICE];
        bus.slice_cin = carry_q;
        if (index_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_sum   = sum_q;
        bus.out_cout  = carry_q;
        bus.out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush overrides both handshakes so no operand is taken and no result is offered
    if (flush) begin
      state_d       = IDLE;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      index_q <= '0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      carry_q <= bus.in_c;
      index_q <= '0;
    end else if (state_q == RUN && !flush) begin
      // inter-slice carry rebuilt from the slice's group generate/propagate
      sum_q[index_q*SLICE +: SLICE] <= bus.slice_s;
      carry_q <= bus.slice_g | (bus.slice_p & carry_q);
      index_q <= (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder with a behavioural cla_4 slice
module tb_nibble_serial_adder;
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } result_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  result_t sb[$];
  logic [4:0] slice_ab;

  nibble_serial_adder_if #(.WIDTH(16), .SLICE(4)) bus ();

  nibble_serial_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    slice_ab      = {1'b0, bus.slice_a} + {1'b0, bus.slice_b};
    bus.slice_g   = slice_ab[4];
    bus.slice_p   = &(bus.slice_a ^ bus.slice_b);
    bus.slice_s   = bus.slice_a + bus.slice_b + {3'b000, bus.slice_cin};
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic result_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] full;
    result_t r;
    full   = {1'b0, a} + {1'b0, b} + {16'h0000, c};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    return r;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    tick();
    bus.in_valid = 1'b0;
    sb.push_back(model(a, b, c));
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic receive(input string tag);
    result_t exp;
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp = sb.pop_front();
      check({tag, "_sum"}, {16'd0, bus.out_sum}, {16'd0, exp.sum});
      check({tag, "_cout"}, {31'd0, bus.out_cout}, {31'd0, exp.cout});
      check({tag, "_ovf"}, {31'd0, bus.out_ovf}, {31'd0, exp.ovf});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_sum"}, {16'd0, bus.out_sum}, 32'd0);
    check({tag, "_out_cout_ovf"}, {30'd0, bus.out_cout, bus.out_ovf}, 32'd0);
    check({tag, "_slice"}, {23'd0, bus.slice_a, bus.slice_b, bus.slice_cin}, 32'd0);
  endtask

  initial begin
    int edges;
    int seen;
    logic [15:0] held_sum;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // T1 plus latency and first-nibble presentation
    send(16'h1234, 16'h4321, 1'b0);
    check("t1_in_ready_run", {31'd0, bus.in_ready}, 32'd0);
    check("t1_slice_nib0", {23'd0, bus.slice_a, bus.slice_b, bus.slice_cin}, {23'd0, 4'h4, 4'h1, 1'b0});
    wait_valid(edges);
    check("t1_latency", edges, 32'd4);

    // T5 backpressure with a competing offer that must be ignored
    held_sum     = bus.out_sum;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hAAAA;
    bus.in_b     = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t5_hold_sum", {16'd0, bus.out_sum}, {16'd0, held_sum});
      check("t5_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    receive("t1");
    check("t5_after_pulse_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_after_pulse_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // T2 full ripple, T3 overflow, T4 carry-in
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(edges);
    check("t2_latency", edges, 32'd4);
    receive("t2");
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_valid(edges);
    receive("t3a");
    send(16'h8000, 16'h8000, 1'b0);
    wait_valid(edges);
    receive("t3b");
    send(16'h00FF, 16'h0000, 1'b1);
    wait_valid(edges);
    receive("t4");

    // T6 abort by reset two cycles after accept
    send(16'h1111, 16'h2222, 1'b0);
    void'(sb.pop_back());
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    check("t6_reset_no_valid", seen, 32'd0);
    check_idle_outputs("t6_reset_after");

    // T6 abort by flush
    send(16'h3333, 16'h4444, 1'b1);
    void'(sb.pop_back());
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      tick();
    end
    check("t6_flush_no_valid", seen, 32'd0);
    check_idle_outputs("t6_flush_after");

    send(16'h1234, 16'h4321, 1'b0);
    wait_valid(edges);
    check("t6_t1_latency", edges, 32'd4);
    receive("t6_t1");
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
